sobel_3x3: RTL and testbench

- Streaming 3x3 Sobel edge detector for a raster-scan 8-bit greyscale stream, one pixel per accepted beat.
- Holds two line buffers and a 3x3 window, and computes Gx and Gy.
- Outputs the saturated magnitude |Gx|+|Gy| for every interior pixel.
- Next generation of the single-line-delay prototype: parametrised frame size, full window, frame tracking.

---
 rtl/sobel_pkg.sv | 20 ++
 rtl/sobel_3x3_if.sv | 28 ++
 rtl/sobel_line_buffer.sv | 27 ++
 rtl/sobel_3x3.sv | 153 +++++++++++++++
 tb/tb_sobel_3x3.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the sobel_3x3 edge detector.
//   DATA_W_DEF : default pixel width
//   GRAD_W     : signed gradient width for the default pixel width
//   MAX_PIX    : largest pixel value for the default pixel width
//   K_EDGE/K_CENTRE : Sobel kernel weights (outer rows/cols vs centre)
//   abs_grad() : magnitude of a signed gradient
package sobel_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int GRAD_W     = DATA_W_DEF + 3;
  localparam int MAX_PIX    = (1 << DATA_W_DEF) - 1;

  localparam int K_EDGE   = 1;
  localparam int K_CENTRE = 2;

  function automatic int abs_grad(input int g);
    return (g < 0) ? -g : g;
  endfunction

endpackage

// File: rtl/sobel_3x3_if.sv
// Pixel-stream bundle for sobel_3x3.
//   valid_in/pixel_in   : input beat, always accepted
//   valid_out/pixel_out : gradient magnitude beat
//   eof_out             : marks the last output of a frame
//   threshold           : present only when SOBEL_THRESH_EN is defined
// master = stream source/sink (bench side), slave = the detector.
interface sobel_3x3_if #(
  parameter int DATA_W = 8
);
  logic              valid_in;
  logic [DATA_W-1:0] pixel_in;
  logic              valid_out;
  logic [DATA_W-1:0] pixel_out;
  logic              eof_out;
`ifdef SOBEL_THRESH_EN
  logic [DATA_W-1:0] threshold;

  modport master (output valid_in, pixel_in, threshold,
                  input  valid_out, pixel_out, eof_out);
  modport slave  (input  valid_in, pixel_in, threshold,
                  output valid_out, pixel_out, eof_out);
`else
  modport master (output valid_in, pixel_in,
                  input  valid_out, pixel_out, eof_out);
  modport slave  (input  valid_in, pixel_in,
                  output valid_out, pixel_out, eof_out);
`endif
endinterface

// File: rtl/sobel_line_buffer.sv
// One image row of pixel storage.
//   clk  : write clock
//   addr : column index (shared read/write address)
//   we   : write enable
//   din  : value written at addr
//   dout : value currently stored at addr (read-before-write)
// Contents are intentionally not reset.
module sobel_line_buffer #(
  parameter int DEPTH  = 128,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic                     we,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign dout = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= din;
  end

endmodule

// File: rtl/sobel_3x3.sv
// Streaming 3x3 Sobel edge detector, raster-order greyscale input.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : sobel_3x3_if slave (valid_in/pixel_in in,
//                valid_out/pixel_out/eof_out out)
// Pipeline: stage 1 line buffers + window, stage 2 Gx/Gy, stage 3
// saturated |Gx|+|Gy|. Output two cycles after the accepting edge.
// Only interior pixels are output; eof_out flags the last one.
// Optional: SOBEL_THRESH_EN adds bus.threshold and binarises the output.
module sobel_3x3
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 128,
  parameter int IMG_HEIGHT = 128,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  sobel_3x3_if.slave  bus
);

  localparam int CW   = $clog2(IMG_WIDTH);
  localparam int RW   = $clog2(IMG_HEIGHT);
  localparam int GW   = DATA_W + (GRAD_W - DATA_W_DEF);
  localparam int MAXV = (1 << DATA_W) - 1;

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              last_col, last_row, win_ok;
  logic [DATA_W-1:0] lb1_rd, lb2_rd;
  logic [DATA_W-1:0] win_q [3][3];
  logic [DATA_W-1:0] win_d [3][3];

  logic              v1_q, eof1_q;
  int                gx_i, gy_i;
  logic signed [GW-1:0] gx_d, gy_d, gx_q, gy_q;
  logic              v2_q, eof2_q;

  logic [GW-1:0]     mag;
  logic [DATA_W-1:0] sat, res;
  logic [DATA_W-1:0] pix_q;
  logic              vout_q, eof_q;

  // Raster position of the pixel presented on this cycle
  always_comb begin
    last_col = (col_q == CW'(IMG_WIDTH - 1));
    last_row = (row_q == RW'(IMG_HEIGHT - 1));
    col_d    = col_q;
    row_d    = row_q;
    if (bus.valid_in) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    // Cols 0/1 never qualify, so window columns left over from the
    // previous row are always shifted out before they are used.
    win_ok = bus.valid_in && (row_q >= RW'(2)) && (col_q >= CW'(2));
  end

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W)) u_lb1 (
    .clk  (clk),
    .addr (col_q),
    .we   (bus.valid_in),
    .din  (bus.pixel_in),
    .dout (lb1_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W)) u_lb2 (
    .clk  (clk),
    .addr (col_q),
    .we   (bus.valid_in),
    .din  (lb1_rd),
    .dout (lb2_rd)
  );

  // Window shift: row 0 oldest (row r-2), column 2 newest
  always_comb begin
    win_d = win_q;
    if (bus.valid_in) begin
      for (int unsigned r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb2_rd;
      win_d[1][2] = lb1_rd;
      win_d[2][2] = bus.pixel_in;
    end
  end

  // Stage 2 gradients; int arithmetic then narrowed (range +-1020 fits GW)
  always_comb begin
    gx_i = K_EDGE   * (int'(win_q[0][2]) - int'(win_q[0][0]))
         + K_CENTRE * (int'(win_q[1][2]) - int'(win_q[1][0]))
         + K_EDGE   * (int'(win_q[2][2]) - int'(win_q[2][0]));
    gy_i = K_EDGE   * (int'(win_q[2][0]) - int'(win_q[0][0]))
         + K_CENTRE * (int'(win_q[2][1]) - int'(win_q[0][1]))
         + K_EDGE   * (int'(win_q[2][2]) - int'(win_q[0][2]));
    gx_d = GW'(gx_i);
    gy_d = GW'(gy_i);
  end

  // Stage 3 magnitude and saturation
  always_comb begin
    mag = GW'(abs_grad(int'(gx_q))) + GW'(abs_grad(int'(gy_q)));
    sat = (mag > GW'(MAXV)) ? DATA_W'(MAXV) : mag[DATA_W-1:0];
`ifdef SOBEL_THRESH_EN
    res = (sat >= bus.threshold) ? DATA_W'(MAXV) : '0;
`else
    res = sat;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
      v1_q   <= 1'b0;
      eof1_q <= 1'b0;
      gx_q   <= '0;
      gy_q   <= '0;
      v2_q   <= 1'b0;
      eof2_q <= 1'b0;
      pix_q  <= '0;
      vout_q <= 1'b0;
      eof_q  <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      win_q  <= win_d;
      v1_q   <= win_ok;
      eof1_q <= win_ok && last_row && last_col;
      gx_q   <= gx_d;
      gy_q   <= gy_d;
      v2_q   <= v1_q;
      eof2_q <= v1_q && eof1_q;
      if (v2_q) pix_q <= res;
      vout_q <= v2_q;
      eof_q  <= v2_q && eof2_q;
    end
  end

  assign bus.valid_out = vout_q;
  assign bus.pixel_out = pix_q;
  assign bus.eof_out   = eof_q;

endmodule

// File: tb/tb_sobel_3x3.sv
// Directed bench for sobel_3x3 on a 16x12 frame.
module tb_sobel_3x3;

  localparam int W    = 16;
  localparam int H    = 12;
  localparam int DW   = 8;
  localparam int NOUT = (H - 2) * (W - 2);
  localparam int THR  = 100;

  typedef struct {
    int cyc;
    int pix;
    int eof;
  } rec_t;

  logic clk;
  logic rst_n;

  sobel_3x3_if #(.DATA_W(DW)) bus ();

  sobel_3x3 #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .DATA_W     (DW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int edge_n   = 0;
  int r_m      = 0;
  int c_m      = 0;
  int fsel     = 0;
  int mode     = 0;
  int last_pix = 0;
  int img [2][H][W];
  rec_t exp_q[$];
  rec_t got_q[$];
  int ref_pix[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference Sobel on image coordinates, centre (r,c)
  function automatic int ref_mag(int f, int r, int c);
    int gx, gy;
    gx = img[f][r-1][c+1] + 2*img[f][r][c+1] + img[f][r+1][c+1]
       - img[f][r-1][c-1] - 2*img[f][r][c-1] - img[f][r+1][c-1];
    gy = img[f][r+1][c-1] + 2*img[f][r+1][c] + img[f][r+1][c+1]
       - img[f][r-1][c-1] - 2*img[f][r-1][c] - img[f][r-1][c+1];
    return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
  endfunction

  function automatic int post(int m);
    int s;
    s = (m > 255) ? 255 : m;
`ifdef SOBEL_THRESH_EN
    return (s >= THR) ? 255 : 0;
`else
    return s;
`endif
  endfunction

  // Expected output for accepted pixel (r,c); window centre is (r-1,c-1)
  function automatic int expect_at(int r, int c);
    int cr, cc, raw;
    cr = r - 1;
    cc = c - 1;
    case (mode)
      0:       raw = 0;
      1:       raw = (cc == W/2 - 1 || cc == W/2) ? 200 : 0;
      2:       raw = (cr == H/2 - 1 || cr == H/2) ? 1020 : 0;
      default: raw = ref_mag(fsel, cr, cc);
    endcase
    return post(raw);
  endfunction

  task automatic step(input logic v);
    bus.valid_in = v;
    bus.pixel_in = v ? DW'(img[fsel][r_m][c_m]) : DW'($urandom);
    @(posedge clk);
    #1;
    edge_n++;
    if (v) begin
      if (r_m >= 2 && c_m >= 2)
        exp_q.push_back('{edge_n + 2, expect_at(r_m, c_m),
                          (r_m == H-1 && c_m == W-1) ? 1 : 0});
      if (c_m == W-1) begin
        c_m = 0;
        r_m = (r_m == H-1) ? 0 : r_m + 1;
      end else begin
        c_m++;
      end
    end
    if (bus.valid_out === 1'b1) begin
      got_q.push_back('{edge_n, int'(bus.pixel_out), int'(bus.eof_out)});
      last_pix = int'(bus.pixel_out);
    end else begin
      chk("eof_idle", 32'(bus.eof_out), 0);
      chk("pix_hold", 32'(bus.pixel_out), last_pix);
    end
  endtask

  task automatic stream_frame(input int duty);
    int sent, iters;
    logic v;
    sent  = 0;
    iters = 0;
    while (sent < H*W && iters < 50*H*W) begin
      v = (duty >= 100) || ($urandom_range(0, 99) < duty);
      step(v);
      if (v) sent++;
      iters++;
    end
    chk("stream_bound", sent, H*W);
  endtask

  task automatic flush();
    repeat (4) step(1'b0);
  endtask

  task automatic compare(input string tag);
    int n;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_cycle"}, got_q[i].cyc, exp_q[i].cyc);
      chk({tag, "_pix"},   got_q[i].pix, exp_q[i].pix);
      chk({tag, "_eof"},   got_q[i].eof, exp_q[i].eof);
    end
  endtask

  function automatic int eof_count();
    int k;
    k = 0;
    foreach (got_q[i]) k += got_q[i].eof;
    return k;
  endfunction

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.valid_in = 1'b0;
    bus.pixel_in = '0;
    @(posedge clk);
    #1;
    edge_n++;
    rst_n    = 1'b1;
    r_m      = 0;
    c_m      = 0;
    last_pix = 0;
    exp_q.delete();
    got_q.delete();
    chk("rst_valid", 32'(bus.valid_out), 0);
    chk("rst_pix",   32'(bus.pixel_out), 0);
    chk("rst_eof",   32'(bus.eof_out),   0);
  endtask

  task automatic clear_q();
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
`ifdef SOBEL_THRESH_EN
    bus.threshold = DW'(THR);
`endif
    do_reset();

    // Flat frame: every output 0, single eof on the final output
    mode = 0; fsel = 0;
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[0][r][c] = 77;
    clear_q();
    stream_frame(100);
    flush();
    compare("flat");
    chk("flat_n", got_q.size(), NOUT);
    chk("flat_eofs", eof_count(), 1);

    // Vertical step at column W/2
    mode = 1;
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[0][r][c] = (c < W/2) ? 0 : 50;
    clear_q();
    stream_frame(100);
    flush();
    compare("vstep");

    // Horizontal step at row H/2 (raw 1020 saturates)
    mode = 2;
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[0][r][c] = (r < H/2) ? 0 : 255;
    clear_q();
    stream_frame(100);
    flush();
    compare("hstep");

    // Random image, gap-free then gapped; outputs must match
    mode = 3;
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[0][r][c] = $urandom_range(0, 255);
    clear_q();
    stream_frame(100);
    flush();
    compare("rand");
    ref_pix.delete();
    foreach (got_q[i]) ref_pix.push_back(got_q[i].pix);
    clear_q();
    stream_frame(40);
    flush();
    compare("gap");
    chk("gap_n", got_q.size(), ref_pix.size());
    for (int i = 0; i < got_q.size() && i < ref_pix.size(); i++)
      chk("gap_vs_nogap", got_q[i].pix, ref_pix[i]);

    // Reset in the middle of a frame, then a full frame
    mode = 1;
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[0][r][c] = (c < W/2) ? 0 : 50;
    for (int i = 0; i < 6*W + 5; i++) step(1'b1);
    do_reset();
    step(1'b0);
    chk("post_rst_valid", got_q.size(), 0);
    clear_q();
    stream_frame(100);
    flush();
    compare("midrst");
    chk("midrst_n", got_q.size(), NOUT);

    // Two back-to-back frames with different content
    mode = 3;
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) begin
      img[0][r][c] = $urandom_range(0, 255);
      img[1][r][c] = $urandom_range(0, 255);
    end
    clear_q();
    fsel = 0;
    stream_frame(100);
    fsel = 1;
    stream_frame(100);
    flush();
    compare("b2b");
    chk("b2b_n", got_q.size(), 2*NOUT);
    chk("b2b_eofs", eof_count(), 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
